// File: rtl/pkt_harness_pkg.sv
// pkt_harness_pkg: shared types, default parameters and the sink backpressure compare.
// Latency: n/a (declarations only).
// Backpressure: bp_ready() decides whether a sink channel accepts in a given phase.
package pkt_harness_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DEF_DW           = 32;
   localparam int DEF_DEPTH        = 4096;
   localparam int DEF_NUM_SINK     = 2;
   localparam int DEF_PW           = 8;
   localparam int DEF_CW           = 32;
   localparam int DEF_IDLE_TIMEOUT = 1024;

   // A zero period or zero threshold means "always ready"; a threshold at or
   // above the period can never be reached, so that channel never accepts.
   function automatic logic bp_ready(input logic [31:0] period,
                                     input logic [31:0] thresh,
                                     input logic [31:0] phase);
      return (period == 32'd0) || (thresh == 32'd0) || (phase >= thresh);
   endfunction

endpackage

// File: rtl/pkt_sink_chan.sv
// pkt_sink_chan: one ejection channel with a programmable periodic ready pattern and a flit counter.
// Latency: ready_o is registered; a pattern change takes effect on the following cycle.
// Backpressure: ready_o high only in the allowed phase window; counter saturates at all-ones.
// Ports: clk/rst (sync, active-high), clr_i (accepted start), period_i/thresh_i pattern,
//   valid_i/data_i ejected flit, ready_o, cnt_o; csum_o only with PKT_HARNESS_CHECKSUM_EN.
module pkt_sink_chan
   import pkt_harness_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int PW = DEF_PW,
   parameter int CW = DEF_CW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic [PW-1:0] period_i,
   input  logic [PW-1:0] thresh_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          ready_o,
   output logic [CW-1:0] cnt_o
`ifdef PKT_HARNESS_CHECKSUM_EN
   ,
   output logic [DW-1:0] csum_o
`endif
);

   logic [PW-1:0] phase_q, phase_d;
   logic          ready_q;
   logic [CW-1:0] cnt_q, cnt_d, cnt_base;
   logic          acc;

   assign acc = valid_i & ready_q;

   always_comb begin
      // Wrap to 0 at the end of the period, and also when the period shrinks
      // below the current phase.
      phase_d = phase_q + PW'(1);
      if ((period_i == '0) || (phase_q >= period_i - PW'(1))) begin
         phase_d = '0;
      end
      // An accepted start clears the count but this cycle's acceptance still counts.
      cnt_base = clr_i ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if (acc && (cnt_base != '1)) begin
         cnt_d = cnt_base + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
         ready_q <= bp_ready(32'(period_i), 32'(thresh_i), 32'd0);
         cnt_q   <= '0;
      end else begin
         phase_q <= phase_d;
         ready_q <= bp_ready(32'(period_i), 32'(thresh_i), 32'(phase_d));
         cnt_q   <= cnt_d;
      end
   end

   assign ready_o = ready_q;
   assign cnt_o   = cnt_q;

`ifdef PKT_HARNESS_CHECKSUM_EN
   logic [DW-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = (clr_i ? '0 : csum_q) ^ (acc ? data_i : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign csum_o = csum_q;
`else
   logic unused_data;
   assign unused_data = ^data_i;
`endif

endmodule

// File: rtl/pkt_traffic_harness.sv
// pkt_traffic_harness: replays a preloaded flit memory into a fabric and absorbs NUM_SINK ejection channels.
// Latency: start in cycle N gives valid_o in N+1; done follows IDLE_TIMEOUT quiet cycles after the last send.
// Backpressure: valid_o/data_o held until ready_i; sinks throttle through per-channel sink_ready_o patterns.
// Ports: clk/rst (sync, active-high); wr_en/wr_addr/wr_data memory load; start/num_flits replay control;
//   data_o/valid_o/ready_i injection; sink_data_i/sink_valid_i/sink_ready_o/bp_period/bp_thresh ejection;
//   sent_cnt/sink_cnt/busy/done status. Define PKT_HARNESS_CHECKSUM_EN to add sink_csum (per-channel XOR).
module pkt_traffic_harness
   import pkt_harness_pkg::*;
#(
   parameter int DW           = DEF_DW,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int NUM_SINK     = DEF_NUM_SINK,
   parameter int PW           = DEF_PW,
   parameter int CW           = DEF_CW,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
   localparam int AW          = $clog2(DEPTH)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [DW-1:0]          wr_data,
   input  logic                   start,
   input  logic [AW:0]            num_flits,
   output logic [DW-1:0]          data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   input  logic [NUM_SINK*DW-1:0] sink_data_i,
   input  logic [NUM_SINK-1:0]    sink_valid_i,
   output logic [NUM_SINK-1:0]    sink_ready_o,
   input  logic [NUM_SINK*PW-1:0] bp_period,
   input  logic [NUM_SINK*PW-1:0] bp_thresh,
   output logic [AW:0]            sent_cnt,
   output logic [NUM_SINK*CW-1:0] sink_cnt,
`ifdef PKT_HARNESS_CHECKSUM_EN
   output logic [NUM_SINK*DW-1:0] sink_csum,
`endif
   output logic                   busy,
   output logic                   done
);

   localparam int SW = AW + 1;
   localparam int QW = $clog2(IDLE_TIMEOUT + 1);

   logic [DW-1:0] mem_q [DEPTH];
   state_e        state_q;
   logic [AW-1:0] addr_q;
   logic [SW-1:0] sent_q, num_q;
   logic [QW-1:0] quiet_q;
   logic          valid_q, busy_q, done_q;
   logic          start_acc, any_acc;

   // No reset on the memory: contents survive rst so a replay can be restarted.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Combinational read: a same-cycle write to addr_q is only visible next cycle.
   assign data_o = mem_q[addr_q];

   assign start_acc = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign any_acc   = |(sink_valid_i & sink_ready_o);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         sent_q  <= '0;
         num_q   <= '0;
         quiet_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_acc) begin
                  num_q   <= num_flits;
                  addr_q  <= '0;
                  sent_q  <= '0;
                  quiet_q <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  if (num_flits == '0) begin
                     state_q <= ST_DRAIN;
                     valid_q <= 1'b0;
                  end else begin
                     state_q <= ST_SEND;
                     valid_q <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (ready_i) begin
                  addr_q <= addr_q + AW'(1);
                  sent_q <= sent_q + SW'(1);
                  if ((sent_q + SW'(1)) == num_q) begin
                     state_q <= ST_DRAIN;
                     valid_q <= 1'b0;
                     quiet_q <= '0;
                  end
               end
            end
            ST_DRAIN: begin
               // Any ejection restarts the quiet window.
               if (any_acc) begin
                  quiet_q <= '0;
               end else if (quiet_q == QW'(IDLE_TIMEOUT - 1)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  quiet_q <= quiet_q + QW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign valid_o  = valid_q;
   assign sent_cnt = sent_q;
   assign busy     = busy_q;
   assign done     = done_q;

   for (genvar g = 0; g < NUM_SINK; g++) begin : g_sink
      pkt_sink_chan #(
         .DW (DW),
         .PW (PW),
         .CW (CW)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .clr_i    (start_acc),
         .period_i (bp_period[g*PW +: PW]),
         .thresh_i (bp_thresh[g*PW +: PW]),
         .valid_i  (sink_valid_i[g]),
         .data_i   (sink_data_i[g*DW +: DW]),
         .ready_o  (sink_ready_o[g]),
         .cnt_o    (sink_cnt[g*CW +: CW])
`ifdef PKT_HARNESS_CHECKSUM_EN
         ,
         .csum_o   (sink_csum[g*DW +: DW])
`endif
      );
   end

endmodule

// File: tb/tb_pkt_traffic_harness.sv
// tb_pkt_traffic_harness: randomized stimulus for pkt_traffic_harness with a queue-based reference model.
// Latency: model predicts every output one cycle ahead from the inputs sampled at the falling edge.
// Backpressure: ready_i and sink valids randomized; sink ready patterns predicted from period/threshold.
module tb_pkt_traffic_harness;

   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int SW    = AW + 1;
   localparam int NS    = 2;
   localparam int PW    = 8;
   localparam int CW    = 8;
   localparam int T     = 32;
   localparam int MAXC  = (1 << CW) - 1;

   logic             clk;
   logic             rst;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             start;
   logic [SW-1:0]    num_flits;
   logic [DW-1:0]    data_o;
   logic             valid_o;
   logic             ready_i;
   logic [NS*DW-1:0] sink_data_i;
   logic [NS-1:0]    sink_valid_i;
   logic [NS-1:0]    sink_ready_o;
   logic [NS*PW-1:0] bp_period;
   logic [NS*PW-1:0] bp_thresh;
   logic [SW-1:0]    sent_cnt;
   logic [NS*CW-1:0] sink_cnt;
`ifdef PKT_HARNESS_CHECKSUM_EN
   logic [NS*DW-1:0] sink_csum;
`endif
   logic             busy;
   logic             done;

   pkt_traffic_harness #(
      .DW (DW), .DEPTH (DEPTH), .NUM_SINK (NS), .PW (PW), .CW (CW), .IDLE_TIMEOUT (T)
   ) dut (
      .clk (clk), .rst (rst),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .start (start), .num_flits (num_flits),
      .data_o (data_o), .valid_o (valid_o), .ready_i (ready_i),
      .sink_data_i (sink_data_i), .sink_valid_i (sink_valid_i), .sink_ready_o (sink_ready_o),
      .bp_period (bp_period), .bp_thresh (bp_thresh),
      .sent_cnt (sent_cnt), .sink_cnt (sink_cnt),
`ifdef PKT_HARNESS_CHECKSUM_EN
      .sink_csum (sink_csum),
`endif
      .busy (busy), .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Stimulus controls
   bit            rdy_rand = 1'b0;
   bit            rdy_fix  = 1'b1;
   int            sink_mode = 0;   // 0 off, 1 random, 2 always valid, 3 forced
   logic [NS-1:0] fv = '0;
   logic [DW-1:0] fd = '0;

   // Reference model state
   logic [DW-1:0] mem_m [DEPTH];
   logic [DW-1:0] exp_q [$];
   bit            chk_en = 1'b0;
   bit            run = 1'b0;
   bit            fin = 1'b0;
   int            sent = 0;
   int            cyc = 0;
   int            last_act = 0;
   int            ph  [NS];
   bit            mr  [NS];
   int            mc  [NS];
   logic [DW-1:0] mcs [NS];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit bp_rule(int p, int t, int phase);
      return (p == 0) || (t == 0) || (phase >= t);
   endfunction

   // Monitor + scoreboard: check the prediction for this cycle, then advance the model.
   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (chk_en) begin
            chk("valid_o", 64'(valid_o), 64'(exp_q.size() > 0));
            chk("busy", 64'(busy), 64'(run));
            chk("done", 64'(done), 64'(fin));
            chk("sent_cnt", 64'(sent_cnt), 64'(sent));
            if (exp_q.size() > 0) chk("data_o", 64'(data_o), 64'(exp_q[0]));
            for (int c = 0; c < NS; c++) begin
               chk("sink_ready", 64'(sink_ready_o[c]), 64'(mr[c]));
               chk("sink_cnt", 64'(sink_cnt[c*CW +: CW]), 64'(mc[c]));
`ifdef PKT_HARNESS_CHECKSUM_EN
               chk("sink_csum", 64'(sink_csum[c*DW +: DW]), 64'(mcs[c]));
`endif
            end
         end
         if (wr_en === 1'b1) mem_m[wr_addr] = wr_data;
         if (rst) begin
            exp_q.delete();
            run  = 1'b0;
            fin  = 1'b0;
            sent = 0;
            for (int c = 0; c < NS; c++) begin
               ph[c]  = 0;
               mr[c]  = bp_rule(int'(bp_period[c*PW +: PW]), int'(bp_thresh[c*PW +: PW]), 0);
               mc[c]  = 0;
               mcs[c] = '0;
            end
            chk_en = 1'b1;
         end else begin
            bit sa;
            bit any;
            sa  = !run && (start === 1'b1);
            any = 1'b0;
            for (int c = 0; c < NS; c++) begin
               int  p;
               int  t;
               bit  acc;
               p   = int'(bp_period[c*PW +: PW]);
               t   = int'(bp_thresh[c*PW +: PW]);
               acc = sink_valid_i[c] && mr[c];
               any = any | acc;
               if (sa) begin
                  mc[c]  = 0;
                  mcs[c] = '0;
               end
               if (acc) begin
                  if (mc[c] < MAXC) mc[c]++;
                  mcs[c] = mcs[c] ^ sink_data_i[c*DW +: DW];
               end
               ph[c] = (p == 0 || ph[c] + 1 >= p) ? 0 : ph[c] + 1;
               mr[c] = bp_rule(p, t, ph[c]);
            end
            if (sa) begin
               sent     = 0;
               run      = 1'b1;
               fin      = 1'b0;
               last_act = cyc;
               for (int i = 0; i < int'(num_flits); i++) exp_q.push_back(mem_m[i % DEPTH]);
            end else if (run) begin
               if (exp_q.size() > 0) begin
                  if (ready_i) begin
                     void'(exp_q.pop_front());
                     sent++;
                     if (exp_q.size() == 0) last_act = cyc;
                  end
               end else if (any) begin
                  last_act = cyc;
               end else if (cyc - last_act == T) begin
                  run = 1'b0;
                  fin = 1'b1;
               end
            end
         end
      end
   end

   // Advance one cycle and drive the randomized/handshake inputs for it.
   task automatic step();
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_en = 1'b0;
      ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
      for (int c = 0; c < NS; c++) begin
         case (sink_mode)
            1:       sink_valid_i[c] = 1'($urandom_range(0, 1));
            2:       sink_valid_i[c] = 1'b1;
            3:       sink_valid_i[c] = fv[c];
            default: sink_valid_i[c] = 1'b0;
         endcase
         sink_data_i[c*DW +: DW] = (sink_mode == 3) ? fd : $urandom();
      end
   endtask

   task automatic wr(int a, logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      step();
   endtask

   task automatic go(int n);
      start     = 1'b1;
      num_flits = SW'(n);
      step();
   endtask

   task automatic wait_done(int budget);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      chk("done_reached", 64'(done), 64'(1));
   endtask

   initial begin : driver
      int k;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; num_flits = '0; ready_i = 1'b0;
      sink_valid_i = '0; sink_data_i = '0; bp_period = '0; bp_thresh = '0;
      repeat (3) step();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) wr(i, $urandom());

      // Back-to-back replay of 8 flits
      rdy_fix = 1'b1;
      go(8);
      wait_done(8 + T + 20);
      chk("t1_sent", 64'(sent_cnt), 64'(8));

      // Stalling fabric; a start during SEND must be ignored
      rdy_rand = 1'b1;
      go(12);
      repeat (3) step();
      go(3);
      wait_done(200);
      chk("t2_sent", 64'(sent_cnt), 64'(12));
      rdy_rand = 1'b0;

      // ch0 ready 5 of 16 cycles, ch1 always ready
      bp_period = {8'd0, 8'd16};
      bp_thresh = {8'd0, 8'd11};
      go(0);
      step();
      sink_mode = 2;
      repeat (160) step();
      sink_mode = 0;
      step();
      chk("bp_ch0_16_11", 64'(sink_cnt[0 +: CW]), 64'(50));
      chk("bp_ch1_always", 64'(sink_cnt[CW +: CW]), 64'(160));

      // Threshold above period: ch0 never ready
      bp_period = {8'd0, 8'd4};
      bp_thresh = {8'd0, 8'd9};
      step();
      sink_mode = 2;
      repeat (40) step();
      sink_mode = 0;
      step();
      chk("bp_ch0_never", 64'(sink_cnt[0 +: CW]), 64'(50));
      chk("bp_ch1_200", 64'(sink_cnt[CW +: CW]), 64'(200));

      // Counter saturation
      sink_mode = 2;
      repeat (100) step();
      sink_mode = 0;
      step();
      chk("ch1_saturate", 64'(sink_cnt[CW +: CW]), 64'(MAXC));
      wait_done(T + 20);

      // Reset after three sends, then restart from mem[0]
      go(10);
      k = 0;
      while (sent_cnt !== SW'(3) && k < 40) begin
         step();
         k++;
      end
      chk("rst_reach3", 64'(sent_cnt), 64'(3));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_valid", 64'(valid_o), 64'(0));
      chk("rst_sent", 64'(sent_cnt), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      rdy_rand = 1'b1;
      go(10);
      wait_done(200);
      chk("rst_resend", 64'(sent_cnt), 64'(10));

      // Random patterns, random sinks, random fabric stalls
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < NS; c++) begin
            bp_period[c*PW +: PW] = PW'($urandom_range(0, 12));
            bp_thresh[c*PW +: PW] = PW'($urandom_range(0, 14));
         end
         sink_mode = 1;
         go(int'($urandom_range(1, 20)));
         repeat (30) step();
         sink_mode = 0;
         wait_done(200);
      end
      rdy_rand = 1'b0;

`ifdef PKT_HARNESS_CHECKSUM_EN
      bp_period = '0;
      bp_thresh = '0;
      step();
      go(0);
      fv = NS'(1);
      fd = 32'h0000_00A5;
      sink_mode = 3;
      step();
      fd = 32'h0000_000F;
      step();
      sink_mode = 0;
      step();
      chk("csum_ch0", 64'(sink_csum[0 +: DW]), 64'h0000_00AA);
      wait_done(T + 20);
`endif

      chk("sb_empty", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
